// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: generic handshaked pipeline stage register for the CPU stage
// boundaries (IF/ID, ID/EXE, EXE/MEM, MEM/WB).
//
// Optional feature macro: PIPE_STAGE_BUF_SKID_EN
//   defined   - adds a skid entry and a registered in_ready
//   undefined - main entry only, in_ready = !out_valid | out_ready
//
// Ports:
//   clk        stage clock, rising edge
//   rst        asynchronous active-low reset
//   in_valid   upstream presents in_data
//   in_ready   stage accepts in_data this cycle
//   in_data    upstream bundle (DATA_W)
//   flush      synchronous squash of all held entries
//   out_valid  out_data holds a valid bundle
//   out_ready  downstream accepts out_data
//   out_data   bundle in the main entry (DATA_W)
//   stall_cnt  saturating count of back-pressured cycles (STALL_CNT_W)
module pipe_stage_buf #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_W-1:0]      in_data,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_W-1:0]      out_data,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam logic [STALL_CNT_W-1:0] STALL_MAX = '1;

    state_t                   state_q;
    state_t                   state_d;
    logic [DATA_W-1:0]        main_q;
    logic [DATA_W-1:0]        main_d;
    logic                     out_valid_q;
    logic [STALL_CNT_W-1:0]   stall_q;
    logic                     in_fire;
    logic                     out_fire;

`ifdef PIPE_STAGE_BUF_SKID_EN
    logic [DATA_W-1:0]        skid_q;
    logic [DATA_W-1:0]        skid_d;
    logic                     in_ready_q;

    // Registered ready: deasserted only while the stage sits in FULL.
    assign in_ready = in_ready_q;
`else
    // Without a skid slot the stage can only take a new bundle when the
    // current one leaves in the same cycle.
    assign in_ready = !out_valid_q | out_ready;
`endif

    assign out_valid = out_valid_q;
    assign out_data  = main_q;
    assign stall_cnt = stall_q;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid_q & out_ready;

    // Next-state and data-path selection; flush squashes valids only.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
`ifdef PIPE_STAGE_BUF_SKID_EN
        skid_d  = skid_q;
`endif
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        state_d = HALF;
                        main_d  = in_data;
                    end
                end
                HALF: begin
                    if (in_fire && out_fire) begin
                        main_d = in_data;
`ifdef PIPE_STAGE_BUF_SKID_EN
                    end else if (in_fire) begin
                        state_d = FULL;
                        skid_d  = in_data;
`endif
                    end else if (out_fire) begin
                        state_d = EMPTY;
                    end
                end
`ifdef PIPE_STAGE_BUF_SKID_EN
                FULL: begin
                    if (out_fire) begin
                        state_d = HALF;
                        main_d  = skid_q;
                    end
                end
`endif
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

    // State, data and valid registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= EMPTY;
            main_q      <= '0;
            out_valid_q <= 1'b0;
`ifdef PIPE_STAGE_BUF_SKID_EN
            skid_q      <= '0;
            in_ready_q  <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            out_valid_q <= (state_d != EMPTY);
`ifdef PIPE_STAGE_BUF_SKID_EN
            skid_q      <= skid_d;
            in_ready_q  <= (state_d != FULL);
`endif
        end
    end

    // Back-pressure counter; saturates and is untouched by flush.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_q <= '0;
        end else if (out_valid_q && !out_ready && (stall_q != STALL_MAX)) begin
            stall_q <= stall_q + STALL_CNT_W'(1);
        end
    end

endmodule
